// File: rtl/arp_ctrl.sv
// ARP resolve/reply sequencer: answers peer requests and resolves one target IP at a time.
// Define ARP_RETRY_EN to compile in the reply timer, retransmissions and the timeout pulse.
//
// state      | meaning
// IDLE       | nothing outstanding, no frame in flight
// SEND       | one-cycle transmit strobe, destination fields loaded
// WAIT_DONE  | frame in flight, waiting for tx_done
// WAIT_REPLY | request sent, waiting for the target's reply
module arp_ctrl #(
    parameter int RETRY_CYCLES = 125_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_start,
    input  logic [31:0] req_ip,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        busy,
    output logic        resolved,
    output logic [47:0] res_mac,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, WAIT_REPLY} state_t;

    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

    state_t      state, state_nxt;
    logic        reply_pend;
    logic [47:0] rep_mac;
    logic [31:0] rep_ip;
    logic [31:0] target_ip;
    logic        tgt_valid;

    logic        rx_req, rx_match, pend_now, tgt_live;
    logic [47:0] cap_mac;
    logic [31:0] cap_ip;
    logic        take_reply, take_req, accept;

`ifdef ARP_RETRY_EN
    localparam int TW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(RETRY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;
    logic          arm_timer, tick, retry_inc, give_up;
`endif

    // A peer request arriving this cycle counts as pending so it wins over req_start.
    assign rx_req    = arp_rx_done & ~arp_rx_type;
    assign rx_match  = arp_rx_done & arp_rx_type & tgt_valid & (src_ip == target_ip);
    assign pend_now  = reply_pend | rx_req;
    assign tgt_live  = tgt_valid & ~rx_match;
    assign cap_mac   = rx_req ? src_mac : rep_mac;
    assign cap_ip    = rx_req ? src_ip : rep_ip;

    assign arp_tx_en = (state == SEND);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        take_reply = 1'b0;
        take_req   = 1'b0;
        accept     = 1'b0;
`ifdef ARP_RETRY_EN
        arm_timer  = 1'b0;
        tick       = 1'b0;
        retry_inc  = 1'b0;
        give_up    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (pend_now) begin
                    take_reply = 1'b1;
                    state_nxt  = SEND;
                end else if (req_start) begin
                    accept    = 1'b1;
                    take_req  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = tgt_live ? WAIT_REPLY : IDLE;
`ifdef ARP_RETRY_EN
                    arm_timer = ~arp_tx_type;
`endif
                end
            end
            WAIT_REPLY: begin
                if (pend_now) begin
                    take_reply = 1'b1;
                    state_nxt  = SEND;
                end else if (rx_match) begin
                    state_nxt = IDLE;
                end
`ifdef ARP_RETRY_EN
                else if (timer == '0) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_inc = 1'b1;
                        take_req  = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        give_up   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    tick = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_pend  <= 1'b0;
            rep_mac     <= '0;
            rep_ip      <= '0;
            target_ip   <= '0;
            tgt_valid   <= 1'b0;
            des_mac     <= '0;
            des_ip      <= '0;
            arp_tx_type <= 1'b0;
            resolved    <= 1'b0;
            res_mac     <= '0;
        end else begin
            // The captured reply is consumed in SEND; a request landing later re-arms it.
            if (rx_req) begin
                reply_pend <= 1'b1;
                rep_mac    <= src_mac;
                rep_ip     <= src_ip;
            end else if (state == SEND && arp_tx_type) begin
                reply_pend <= 1'b0;
            end

            if (take_reply) begin
                des_mac     <= cap_mac;
                des_ip      <= cap_ip;
                arp_tx_type <= 1'b1;
            end else if (take_req) begin
                des_mac     <= BCAST_MAC;
                des_ip      <= accept ? req_ip : target_ip;
                arp_tx_type <= 1'b0;
            end

            if (accept) begin
                target_ip <= req_ip;
                tgt_valid <= 1'b1;
                resolved  <= 1'b0;
            end else if (rx_match) begin
                tgt_valid <= 1'b0;
                resolved  <= 1'b1;
                res_mac   <= src_mac;
            end
`ifdef ARP_RETRY_EN
            else if (give_up) begin
                tgt_valid <= 1'b0;
                resolved  <= 1'b0;
            end
`endif
        end
    end

`ifdef ARP_RETRY_EN
    // Down-counter loaded on each request's tx_done; holds its value while a reply is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            retry_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= give_up;
            if (accept)         retry_cnt <= '0;
            else if (retry_inc) retry_cnt <= retry_cnt + RW'(1);
            if (arm_timer)      timer <= TIMER_LOAD;
            else if (tick)      timer <= timer - TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/arp_ctrl.md
ARP_CTRL -- requirements
Module: arp_ctrl

Interface
REQ-001 Parameter RETRY_CYCLES, default 125_000_000, clk cycles to wait for an ARP reply before retransmitting (1 s at 125 MHz).
REQ-002 Parameter MAX_RETRY, default 3, number of retransmissions after the first request before giving up.
REQ-003 Port clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port req_start  in  1  one-cycle pulse; start resolving req_ip.
REQ-006 Port req_ip  in  32  IP to resolve; sampled on an accepted req_start.
REQ-007 Port arp_rx_done  in  1  one-cycle pulse; ARP frame parsed by the receiver.
REQ-008 Port arp_rx_type  in  1  0 = peer request, 1 = peer reply; valid with arp_rx_done.
REQ-009 Port src_mac / src_ip  in  48 / 32  sender MAC and IP of the parsed frame; valid with arp_rx_done.
REQ-010 Port tx_done  in  1  one-cycle pulse from the ARP transmitter at end of frame.
REQ-011 Port arp_tx_en / arp_tx_type  out  1 / 1  transmit strobe; type 0 = request, 1 = reply.
REQ-012 Port des_mac / des_ip  out  48 / 32  destination fields for the transmitter; stable from arp_tx_en until tx_done.
REQ-013 Port busy  out  1  high whenever state is not IDLE.
REQ-014 Port resolved / res_mac  out  1 / 48  target resolved flag and its MAC.
REQ-015 Port timeout  out  1  one-cycle pulse when retries are exhausted.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_DONE and WAIT_REPLY.
REQ-017 arp_rx_done with arp_rx_type=0 SHALL set reply_pend and capture src_mac/src_ip into the reply registers in any state; a later request SHALL overwrite an unsent one.
REQ-018 From IDLE or WAIT_REPLY with reply_pend=1, the FSM SHALL go to SEND with reply selected; a pending reply has priority over an own request.
REQ-019 From IDLE with reply_pend=0, an accepted req_start SHALL latch req_ip as target, clear resolved, clear the retry count and go to SEND with request selected.
REQ-020 req_start SHALL be ignored while busy=1, or in the same cycle a reply is taken.
REQ-021 SEND SHALL last one cycle. It SHALL drive arp_tx_en=1 for that cycle and load des_mac/des_ip/arp_tx_type. Reply: captured MAC/IP, type 1. Request: 48'hFF_FF_FF_FF_FF_FF/target, type 0. It SHALL then go to WAIT_DONE.
REQ-022 arp_tx_en SHALL be low for at least 2 cycles between pulses, so the transmitter's edge detector sees each one.
REQ-023 WAIT_DONE SHALL hold until tx_done. A reply SHALL clear reply_pend (unless a new request arrived in that same cycle) and return to WAIT_REPLY if a target is outstanding, else to IDLE. A request SHALL go to WAIT_REPLY with the timer cleared.
REQ-024 arp_rx_done with arp_rx_type=1 and src_ip equal to the outstanding target SHALL set resolved=1 and res_mac=src_mac. The FSM SHALL go to IDLE from WAIT_REPLY, or after tx_done if it is in SEND or WAIT_DONE. Non-matching replies SHALL be ignored.
REQ-025 The WAIT_REPLY timer SHALL count only in WAIT_REPLY and SHALL freeze while a reply is in flight.
REQ-026 resolved/res_mac SHALL hold until the next accepted req_start.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and clear reply_pend, the timer, the retry count and the target.
REQ-028 While rst_n is low, all outputs SHALL be 0: arp_tx_en, arp_tx_type, des_mac, des_ip, busy, resolved, res_mac, timeout.
REQ-029 A reset asserted mid-frame SHALL discard the transfer; no arp_tx_en SHALL follow release without new stimulus.

Configuration
REQ-030 Macro ARP_RETRY_EN SHALL compile in the retry timer.
REQ-031 With ARP_RETRY_EN defined: when the timer reaches RETRY_CYCLES-1 and retries < MAX_RETRY, the block SHALL increment retries and go to SEND with request selected. When retries = MAX_RETRY, it SHALL pulse timeout for one cycle and go to IDLE with resolved=0.
REQ-032 Without ARP_RETRY_EN: there SHALL be no timer or retry logic; WAIT_REPLY SHALL be left only by a matching reply, a pending reply, or reset; timeout SHALL be tied 0.

Verification
REQ-033 Scenario: req_start with req_ip=192.168.1.11, then tx_done, then reply from 192.168.1.11 MAC 00_11_22_33_44_55 -> one arp_tx_en with type 0, des_mac all-FF; then resolved=1, res_mac=00_11_22_33_44_55, busy=0.
REQ-034 Scenario: peer request from 192.168.1.20 while IDLE -> arp_tx_en type 1, des_ip=192.168.1.20; busy low after tx_done.
REQ-035 Scenario: peer request arrives during WAIT_REPLY -> reply sent, FSM returns to WAIT_REPLY, a later matching reply still sets resolved.
REQ-036 Scenario (ARP_RETRY_EN, RETRY_CYCLES=100, MAX_RETRY=2, no reply) -> 3 request strobes about 100 cycles apart, then one timeout pulse, busy=0.
REQ-037 Scenario: req_start and peer request in the same cycle from IDLE -> reply sent first, then req_start ignored; non-matching reply leaves resolved=0.
REQ-038 Scenario: rst_n pulled low during WAIT_DONE -> all outputs 0 at once; no arp_tx_en after release.
